// File: rtl/ring_johnson_counter_param_if.sv
// Control and status bundle for the ring/Johnson shift counter.
// The master drives the controls and load data; the slave drives the counter state and flags.
interface ring_johnson_counter_param_if #(
  parameter int unsigned WIDTH = 4
);
  logic             En;
  logic             Mode;
  logic             Dir;
  logic             Preset;
  logic             Load;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             Wrap;
  logic             Illegal;

  modport master (
    output En, Mode, Dir, Preset, Load, D,
    input  Q, Wrap, Illegal
  );

  modport slave (
    input  En, Mode, Dir, Preset, Load, D,
    output Q, Wrap, Illegal
  );
endinterface

// File: rtl/ring_johnson_counter_param.sv
// Parametrised ring (one-hot) / Johnson counter with load, preset, illegal-state detection,
// optional self-correction, and a one-cycle Wrap pulse on each completed period.
module ring_johnson_counter_param #(
  parameter int unsigned WIDTH        = 4,
  parameter bit          AUTO_CORRECT = 1'b1
) (
  input logic                          Clock,
  input logic                          Resetn,
  ring_johnson_counter_param_if.slave  bus
);

  localparam logic [WIDTH-1:0] S0  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] shift_val;
  logic             ring_legal;
  logic             msb_run;
  logic             lsb_run;
  logic             illegal;

  // Power-of-two test: nonzero and clearing the lowest set bit leaves nothing.
  always_comb begin
    ring_legal = (q_q != '0) && ((q_q & (q_q - ONE)) == '0);
  end

  // A set bit must have a set neighbour on the anchor side for the run to be contiguous.
  always_comb begin
    msb_run = &(~q_q[WIDTH-2:0] | q_q[WIDTH-1:1]);
    lsb_run = &(~q_q[WIDTH-1:1] | q_q[WIDTH-2:0]);
  end

  always_comb begin
    if (bus.Mode) illegal = !(msb_run || lsb_run);
    else          illegal = !ring_legal;
  end

  always_comb begin
    shift_val = q_q;
    case ({bus.Mode, bus.Dir})
      2'b00:   shift_val = {q_q[0], q_q[WIDTH-1:1]};
      2'b01:   shift_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      2'b10:   shift_val = {~q_q[0], q_q[WIDTH-1:1]};
      default: shift_val = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
    endcase
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (bus.Load) begin
      q_d = bus.D;
    end else if (bus.Preset) begin
      q_d = S0;
    end else if (bus.En) begin
      if (illegal && AUTO_CORRECT) begin
        q_d = S0;
      end else begin
        q_d    = shift_val;
        // Only a legal walk back to S0 counts as a completed period.
        wrap_d = (shift_val == S0) && !illegal;
      end
    end
  end

  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      q_q    <= S0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.Q       = q_q;
  assign bus.Wrap    = wrap_q;
  assign bus.Illegal = illegal;

endmodule

// File: tb/tb_ring_johnson_counter_param.sv
// Scoreboard bench: two 4-bit counters (auto-correct on/off) share stimulus; expected
// Q/Wrap/Illegal for each are queued per step and checked by an independent monitor.
module tb_ring_johnson_counter_param;

  logic Clock;
  logic Resetn;

  ring_johnson_counter_param_if #(.WIDTH(4)) ifa ();
  ring_johnson_counter_param_if #(.WIDTH(4)) ifb ();

  ring_johnson_counter_param #(.WIDTH(4), .AUTO_CORRECT(1'b1)) dut_a (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (ifa)
  );

  ring_johnson_counter_param #(.WIDTH(4), .AUTO_CORRECT(1'b0)) dut_b (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (ifb)
  );

  typedef struct {
    string      name;
    logic [5:0] exp_a;
    logic [5:0] exp_b;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  event      sample_ev;
  int        checks   = 0;
  int        failures = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic cmp(input string name, input string inst, input logic [5:0] act,
                     input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (%s): Q/Wrap/Illegal got %b_%b_%b want %b_%b_%b", name, inst,
               act[5:2], act[1], act[0], exp[5:2], exp[1], exp[0]);
    end
  endtask

  initial begin : monitor
    sb_entry_t e;
    forever begin
      @(negedge Clock or sample_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp(e.name, "ac1", {ifa.Q, ifa.Wrap, ifa.Illegal}, e.exp_a);
        cmp(e.name, "ac0", {ifb.Q, ifb.Wrap, ifb.Illegal}, e.exp_b);
      end
    end
  end

  task automatic drive(input logic en, input logic mode, input logic dir, input logic pre,
                       input logic load, input logic [3:0] d);
    ifa.En = en;  ifa.Mode = mode; ifa.Dir = dir; ifa.Preset = pre; ifa.Load = load; ifa.D = d;
    ifb.En = en;  ifb.Mode = mode; ifb.Dir = dir; ifb.Preset = pre; ifb.Load = load; ifb.D = d;
  endtask

  task automatic push(input string name, input logic [5:0] ea, input logic [5:0] eb);
    sb_entry_t e;
    e.name  = name;
    e.exp_a = ea;
    e.exp_b = eb;
    sb_q.push_back(e);
  endtask

  // One clocked step; expected values are {Q, Wrap, Illegal} after the edge.
  task automatic step2(input string name, input logic en, input logic mode, input logic dir,
                       input logic pre, input logic load, input logic [3:0] d,
                       input logic [5:0] ea, input logic [5:0] eb);
    drive(en, mode, dir, pre, load, d);
    @(posedge Clock);
    push(name, ea, eb);
    @(negedge Clock);
    #1;
  endtask

  task automatic step(input string name, input logic en, input logic mode, input logic dir,
                      input logic pre, input logic load, input logic [3:0] d,
                      input logic [5:0] e);
    step2(name, en, mode, dir, pre, load, d, e, e);
  endtask

  initial begin
    Resetn = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    repeat (2) @(negedge Clock);
    #1;
    push("reset_state", 6'b1000_0_0, 6'b1000_0_0);
    ->sample_ev;
    #1;
    Resetn = 1'b0;

    // Ring toward LSB, then toward MSB
    step("ring_d0_1", 1, 0, 0, 0, 0, 4'h0, 6'b0100_0_0);
    step("ring_d0_2", 1, 0, 0, 0, 0, 4'h0, 6'b0010_0_0);
    step("ring_d0_3", 1, 0, 0, 0, 0, 4'h0, 6'b0001_0_0);
    step("ring_d0_4", 1, 0, 0, 0, 0, 4'h0, 6'b1000_1_0);
    step("ring_hold", 0, 0, 0, 0, 0, 4'h0, 6'b1000_0_0);
    step("ring_d1_1", 1, 0, 1, 0, 0, 4'h0, 6'b0001_0_0);
    step("ring_d1_2", 1, 0, 1, 0, 0, 4'h0, 6'b0010_0_0);
    step("ring_d1_3", 1, 0, 1, 0, 0, 4'h0, 6'b0100_0_0);
    step("ring_d1_4", 1, 0, 1, 0, 0, 4'h0, 6'b1000_1_0);

    // Johnson toward LSB: full 8-state period
    step("john_d0_1", 1, 1, 0, 0, 0, 4'h0, 6'b1100_0_0);
    step("john_d0_2", 1, 1, 0, 0, 0, 4'h0, 6'b1110_0_0);
    step("john_d0_3", 1, 1, 0, 0, 0, 4'h0, 6'b1111_0_0);
    step("john_d0_4", 1, 1, 0, 0, 0, 4'h0, 6'b0111_0_0);
    step("john_d0_5", 1, 1, 0, 0, 0, 4'h0, 6'b0011_0_0);
    step("john_d0_6", 1, 1, 0, 0, 0, 4'h0, 6'b0001_0_0);
    step("john_d0_7", 1, 1, 0, 0, 0, 4'h0, 6'b0000_0_0);
    step("john_d0_8", 1, 1, 0, 0, 0, 4'h0, 6'b1000_1_0);
    step("john_d1_1", 1, 1, 1, 0, 0, 4'h0, 6'b0000_0_0);
    step("john_d1_2", 1, 1, 1, 0, 0, 4'h0, 6'b0001_0_0);

    // Illegal load in ring mode: corrected vs. shifted as-is
    step("ld_0110", 0, 0, 0, 0, 1, 4'b0110, 6'b0110_0_1);
    step2("illegal_sh1", 1, 0, 0, 0, 0, 4'h0, 6'b1000_0_0, 6'b0011_0_1);
    step2("illegal_sh2", 1, 0, 0, 0, 0, 4'h0, 6'b0100_0_0, 6'b1001_0_1);

    // Priority and hold
    step("preset_sync", 1, 0, 0, 1, 0, 4'h0, 6'b1000_0_0);
    step("load_over_pre", 1, 0, 0, 1, 1, 4'b0010, 6'b0010_0_0);
    step("preset_alone", 1, 0, 0, 1, 0, 4'b0010, 6'b1000_0_0);
    step("hold_1", 0, 0, 0, 0, 0, 4'h0, 6'b1000_0_0);
    step("hold_2", 0, 0, 0, 0, 0, 4'h0, 6'b1000_0_0);
    step("hold_3", 0, 0, 0, 0, 0, 4'h0, 6'b1000_0_0);

    // Mode switch from a ring state that is not a Johnson state
    step("ld_0100", 0, 0, 0, 0, 1, 4'b0100, 6'b0100_0_0);
    step("mode_switch", 0, 1, 0, 0, 0, 4'h0, 6'b0100_0_1);
    step2("switch_shift", 1, 1, 0, 0, 0, 4'h0, 6'b1000_0_0, 6'b1010_0_1);

    // Asynchronous reset mid-cycle from a Johnson state
    step("ld_0011", 0, 1, 0, 0, 1, 4'b0011, 6'b0011_0_0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    @(posedge Clock);
    #2;
    Resetn = 1'b1;
    #1;
    push("async_reset", 6'b1000_0_0, 6'b1000_0_0);
    ->sample_ev;
    #1;
    Resetn = 1'b0;
    step("post_reset", 1, 1, 0, 0, 0, 4'h0, 6'b1100_0_0);

    @(negedge Clock);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_johnson_counter_param.md
Name: ring_johnson_counter_param

Overview:
- Parametrised shift-register counter that generalises the team's fixed 4-bit ring counter.
- Supports ring (one-hot) or Johnson (twisted-ring) mode, selectable shift direction, count enable, synchronous preset and parallel load.
- Detects illegal states and optionally self-corrects them; flags each completed cycle.
- Used as a one-hot sequencer/phase generator in lab datapaths (LED walkers, multiplexed display scan).

Parameters:
- WIDTH, 4, number of stages; legal range 2..32.
- AUTO_CORRECT, 1, 1 = an enabled shift from an illegal state forces S0; 0 = shift as-is.

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous, active-high reset.
- En  in  1  shift enable.
- Mode  in  1  0 = ring, 1 = Johnson.
- Dir  in  1  0 = shift toward LSB, 1 = shift toward MSB.
- Preset  in  1  synchronous return to S0.
- Load  in  1  synchronous parallel load of D.
- D  in  WIDTH  parallel load data.
- Q  out  WIDTH  counter state.
- Wrap  out  1  registered one-cycle pulse when a shift returns Q to S0.
- Illegal  out  1  combinational; Q is not a legal state for the current Mode.

Behaviour:
- Clocking and reset: Clock is the clock; Resetn is asynchronous and active-high. While Resetn=1, Q=S0 and Wrap=0 immediately, independent of Clock.
- S0 = MSB only set (WIDTH=4: 1000). S0 is legal in both modes.
- Priority at each rising Clock edge: Resetn > Load > Preset > En > hold.
- Load: Q<=D, Wrap<=0. D is not checked for legality.
- Preset (Load=0): Q<=S0, Wrap<=0.
- En=1 with Load=0 and Preset=0:
  - If Illegal=1 and AUTO_CORRECT=1: Q<=S0, Wrap<=0.
  - Otherwise Q<=shift(Q), where:
    - Ring, Dir=0: {Q[0], Q[W-1:1]}
    - Ring, Dir=1: {Q[W-2:0], Q[W-1]}
    - Johnson, Dir=0: {~Q[0], Q[W-1:1]}
    - Johnson, Dir=1: {Q[W-2:0], ~Q[W-1]}
  - Wrap<=1 if the shifted value equals S0 and the pre-shift Q was legal; else Wrap<=0.
- En=0 (no Load, no Preset): Q holds, Wrap<=0.
- Wrap is high for exactly one cycle per completed period. Period is WIDTH shifts in ring mode, 2*WIDTH shifts in Johnson mode (either direction).
- Legality:
  - Ring: exactly one bit set.
  - Johnson: Q is a contiguous run of ones anchored at MSB or LSB, or all-0, or all-1 (2*WIDTH states).
- Illegal is purely combinational from Q and Mode. It is never registered or latched.
- Mode or Dir change takes effect on the next enabled edge, with no flush. If Q is illegal in the new Mode, Illegal asserts immediately and the AUTO_CORRECT rule applies.
- Reset mid-operation: Q returns to S0 with no partial shift. The first enabled edge after Resetn falls performs a normal shift from S0.
- All registered outputs change only on a rising Clock edge or an asynchronous reset.
- No latches. Next-state logic is fully combinational with a default assignment.

Test Plan:
1. Async reset: WIDTH=4, Q=0011 in Johnson mode, assert Resetn mid-cycle -> Q=1000 and Wrap=0 before the next edge; Illegal=0.
2. Ring, Dir=0, En=1 from S0 -> Q sequence 0100, 0010, 0001, 1000; Wrap=1 only in the cycle after the 4th edge. Repeat with Dir=1 -> 0001, 0010, 0100, 1000.
3. Johnson, Dir=0, En=1 from S0 -> 1100, 1110, 1111, 0111, 0011, 0001, 0000, 1000; Wrap=1 only after the 8th edge; Illegal stays 0 throughout.
4. Load D=0110 in ring mode:
   - AUTO_CORRECT=1 -> Illegal=1; next enabled edge gives Q=1000, Wrap=0.
   - AUTO_CORRECT=0 -> Q=0011, then 1001; Illegal stays 1; no Wrap.
5. Priority: Load=1, Preset=1, D=0010 on the same edge -> Q=0010. Preset alone -> Q=1000. En=0 for 3 edges -> Q holds, Wrap=0.
6. Mode switch: ring Q=0100, switch to Johnson -> Illegal=1 at once; with AUTO_CORRECT=1 the next enabled edge gives Q=1000.
